// File: rtl/rateconv_pkg.sv
// Shared types and defaults for the rate-converter output stage.
package rateconv_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefDepth = 8;

   typedef enum logic {
      StPrime,
      StRun
   } state_e;

   typedef struct packed {
      logic [DefDataW-1:0] left;
      logic [DefDataW-1:0] right;
   } frame_t;

endpackage

// File: rtl/cic_stereo_outbuf_if.sv
// Decimator input stream and frame-rate output side of the stereo output buffer.
interface cic_stereo_outbuf_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_channel;
   logic [1:0]        in_error;
   logic              in_startofpacket;
   logic              in_endofpacket;
   logic              out_tick;
   logic [DATA_W-1:0] out_left;
   logic [DATA_W-1:0] out_right;
   logic              out_strobe;
   logic [LW-1:0]     level;
   logic              running;
   logic [15:0]       underrun_cnt;
   logic [15:0]       sync_err_cnt;

   modport master (
      output in_data, in_valid, in_channel, in_error, in_startofpacket, in_endofpacket,
      output out_tick,
      input  in_ready, out_left, out_right, out_strobe, level, running,
      input  underrun_cnt, sync_err_cnt
   );

   modport slave (
      input  in_data, in_valid, in_channel, in_error, in_startofpacket, in_endofpacket,
      input  out_tick,
      output in_ready, out_left, out_right, out_strobe, level, running,
      output underrun_cnt, sync_err_cnt
   );

endinterface

// File: rtl/stereo_frame_fifo.sv
// Synchronous frame FIFO with show-ahead read data and wrap-bit pointers.
module stereo_frame_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en_i,
   input  logic [W-1:0]               din_i,
   input  logic                       rd_en_i,
   output logic [W-1:0]               dout_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_wr, do_rd;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr   = wr_en_i && !full_o;
   assign do_rd   = rd_en_i && !empty_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/cic_stereo_outbuf.sv
// Pairs interleaved L/R decimator samples into frames and releases one per output tick.
module cic_stereo_outbuf import rateconv_pkg::*; #(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned DEPTH     = DefDepth,
   parameter int unsigned PRIME_LVL = DEPTH / 2
) (
   input  logic                clk,
   input  logic                reset,
   cic_stereo_outbuf_if.slave  bus
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] PrimeLvl = LW'(PRIME_LVL);

   state_e              state_q, state_d;
   logic                pend_q, pend_d;
   logic [DATA_W-1:0]   left_q, left_d;
   logic [DATA_W-1:0]   out_left_q, out_right_q;
   logic                out_strobe_q;
   logic [15:0]         underrun_q, sync_err_q;

   logic                accept, wr_en, rd_en, sync_inc, under_inc;
   logic                fifo_full, fifo_empty;
   logic [LW-1:0]       fifo_level;
   logic [2*DATA_W-1:0] fifo_dout;
   logic                unused_pkt;

   assign unused_pkt = ^{bus.in_startofpacket, bus.in_endofpacket};
   assign accept     = bus.in_valid && !fifo_full;

   stereo_frame_fifo #(
      .W     (2 * DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en_i (wr_en),
      .din_i   ({left_q, bus.in_data}),
      .rd_en_i (rd_en),
      .dout_o  (fifo_dout),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // A right sample completes a frame only if an error-free left is waiting.
   always_comb begin
      pend_d   = pend_q;
      left_d   = left_q;
      wr_en    = 1'b0;
      sync_inc = 1'b0;
      if (accept) begin
         if (bus.in_error != 2'b00) begin
            pend_d = 1'b0;
         end else if (!bus.in_channel) begin
            left_d   = bus.in_data;
            pend_d   = 1'b1;
            sync_inc = pend_q;
         end else if (pend_q) begin
            wr_en  = 1'b1;
            pend_d = 1'b0;
         end else begin
            sync_inc = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_en     = 1'b0;
      under_inc = 1'b0;
      unique case (state_q)
         StPrime: if (fifo_level >= PrimeLvl) state_d = StRun;
         StRun: begin
            if (bus.out_tick) begin
               if (fifo_empty) begin
                  under_inc = 1'b1;
                  state_d   = StPrime;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         default: state_d = StPrime;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StPrime;
         pend_q       <= 1'b0;
         left_q       <= '0;
         out_left_q   <= '0;
         out_right_q  <= '0;
         out_strobe_q <= 1'b0;
         underrun_q   <= '0;
         sync_err_q   <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         left_q       <= left_d;
         out_strobe_q <= bus.out_tick;
         if (rd_en) begin
            out_left_q  <= fifo_dout[2*DATA_W-1:DATA_W];
            out_right_q <= fifo_dout[DATA_W-1:0];
         end
         if (under_inc && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
         if (sync_inc && sync_err_q != 16'hFFFF) sync_err_q <= sync_err_q + 16'd1;
      end
   end

   assign bus.in_ready     = !fifo_full;
   assign bus.out_left     = out_left_q;
   assign bus.out_right    = out_right_q;
   assign bus.out_strobe   = out_strobe_q;
   assign bus.level        = fifo_level;
   assign bus.running      = (state_q == StRun);
   assign bus.underrun_cnt = underrun_q;
   assign bus.sync_err_cnt = sync_err_q;

endmodule

// File: doc/cic_stereo_outbuf.md
# cic_stereo_outbuf

Stereo output buffer directly downstream of the 37:1 CIC decimator in the rate converter. Consumes the decimator's interleaved Avalon-ST stream (16-bit samples, 1-bit channel tag) and pairs left/right samples into frames. Buffers frames in a small FIFO and releases one frame per output-rate tick (e.g. 48 kHz) to the mixer/DAC side. Absorbs decimator burstiness and records underruns and channel-sync errors.

## Interface
- DATA_W, 16, sample width
- DEPTH, 8, FIFO depth in stereo frames; power of 2, ≥4
- PRIME_LVL, DEPTH/2, frames required before output starts or restarts
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  DATA_W  sample from decimator
- in_valid  in  1  sample valid
- in_ready  out  1  buffer can accept a sample
- in_channel  in  1  0 = left, 1 = right
- in_error  in  2  nonzero = sample corrupt
- in_startofpacket, in_endofpacket  in  1  accepted, ignored
- out_tick  in  1  one-cycle output-rate strobe
- out_left, out_right  out  DATA_W  current output frame
- out_strobe  out  1  one-cycle pulse: new frame presented
- level  out  $clog2(DEPTH)+1  frames in FIFO
- running  out  1  high in RUN state
- underrun_cnt  out  16  saturating underrun count
- sync_err_cnt  out  16  saturating pairing-error count

## Operation
- Accept a sample when in_valid && in_ready; in_ready = (level != DEPTH), combinational from registered level.
- Pairing: `pend` flag plus a left holding register.
  - ch0 accepted, no error: latch left, set pend. If pend was already set: overwrite and sync_err_cnt++.
  - ch1 accepted, no error, pend set: write {left, in_data} to FIFO and clear pend.
  - ch1 accepted with pend clear: discard and sync_err_cnt++.
  - in_error != 0: discard the sample and clear pend. No counter change.
- States: PRIME (reset state) and RUN.
  - PRIME→RUN: any cycle with level ≥ PRIME_LVL.
  - RUN→PRIME: a tick with the FIFO empty.
- Tick in RUN, FIFO non-empty: pop a frame into out_left/out_right.
- Tick in RUN, FIFO empty: hold the outputs, underrun_cnt++ (saturate at 0xFFFF), go to PRIME.
- Tick in PRIME: hold the outputs. No pop, no count.
- out_strobe pulses on every tick, whatever the state.
- Write and pop in the same cycle: both occur and level is unchanged.
- A tick on an empty FIFO in the same cycle as a write is an underrun. The written frame stays in the FIFO.
- Counters saturate at 0xFFFF and do not wrap.
- Reset values: out_left = out_right = 0, out_strobe = 0, level = 0, in_ready = 1, running = 0, both counters 0, pend = 0, state PRIME, FIFO pointers 0.
- Reset asserted mid-operation discards all buffered frames and any pending left sample, with immediate asynchronous effect.

## Timing
- Input to FIFO: the frame is written on the edge that accepts ch1. level increments on that edge.
- Tick sampled at edge N: out_left/out_right update at edge N and out_strobe is high for the cycle after edge N. Latency is 1 cycle from tick to data.
- in_ready falls in the cycle after the write that fills the FIFO.
- in_ready rises in the cycle after a pop from a full FIFO.
- running follows the state register with no extra delay.
- out_tick asserted for more than one cycle counts once per high cycle. Ticks must therefore be one-cycle pulses.

## Structure
- Package `rateconv_pkg` holds:
  - the PRIME/RUN state enum,
  - the default DATA_W and DEPTH constants,
  - the frame typedef {left, right}.
- Sub-module `stereo_frame_fifo`: synchronous FIFO, 2×DATA_W wide, DEPTH deep. Provides wr_en, rd_en, dout, level, full and empty, with registered pointers and an extra wrap bit.
- Top level holds the pairing logic, the state machine, the output registers and the counters.

## Test plan
- Reset, feed L=0x1111/R=0x2222 ×4, then tick → out_left=0x1111, out_right=0x2222, out_strobe 1 cycle after tick, level 3.
- Feed 8 frames, no ticks → in_ready=0 after the 8th frame; the next sample is not accepted. Tick → in_ready=1 the following cycle, level 7.
- RUN, drain FIFO, tick on empty → outputs held, underrun_cnt=1, running=0. Feed 3 frames → still PRIME. 4th frame → running=1.
- Sequence ch1, ch0, ch0, ch1 → sync_err_cnt=2 and exactly one frame is written, containing the second left.
- ch0 with in_error=2'b01, then ch1 → both discarded, sync_err_cnt=1, level unchanged.
- Assert reset with 5 frames buffered and pend set → all outputs at their reset values immediately, and the next tick produces no pop.
